// File: rtl/if_id_stage.sv
// Fetch front end: PC register, IF/ID pipeline register, load-use hazard
// detection, taken-branch redirect/flush and a saturating stall counter.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      imem_rdata,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_target;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_src_match;
  logic             w_stall;
  logic             w_cnt_sat;

  logic [31:0]      w_nxt_pc;
  logic [31:0]      w_nxt_instr;
  logic [31:0]      w_nxt_pc4;
  logic             w_nxt_valid;
  logic [CNT_W-1:0] w_nxt_cnt;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Masking keeps every target bit in the expression while word-aligning it.
  assign w_target   = branch_target & ~32'd3;

  assign w_rs        = r_instr[25:21];
  assign w_rt        = r_instr[20:16];
  assign w_src_match = (ex_rt == w_rs) || (ex_rt == w_rt);
  assign w_stall     = r_valid && ex_MemRead && (ex_rt != 5'd0) && w_src_match;
  assign w_cnt_sat   = &r_cnt;

  // Redirect beats stall: the stalled instruction is on the wrong path.
  always_comb begin
    w_nxt_pc    = w_pc_plus4;
    w_nxt_instr = imem_rdata;
    w_nxt_pc4   = w_pc_plus4;
    w_nxt_valid = 1'b1;
    w_nxt_cnt   = r_cnt;
    if (branch_taken) begin
      w_nxt_pc    = w_target;
      w_nxt_instr = NOP_INSTR;
      w_nxt_pc4   = 32'd0;
      w_nxt_valid = 1'b0;
    end else if (w_stall) begin
      w_nxt_pc    = r_pc;
      w_nxt_instr = r_instr;
      w_nxt_pc4   = r_pc4;
      w_nxt_valid = r_valid;
      if (!w_cnt_sat) begin
        w_nxt_cnt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_nxt_pc;
      r_instr <= w_nxt_instr;
      r_pc4   <= w_nxt_pc4;
      r_valid <= w_nxt_valid;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign pc          = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign stall       = w_stall;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed vectors push expectations, a
// monitor pops them and checks the stall flag before and the state after each edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ex_MemRead = 1'b0;
  logic [4:0]  ex_rt = '0;

  logic [31:0] pc0, ins0, pc40;
  logic        v0, st0;
  logic [15:0] cnt0;
  logic [31:0] pc1, ins1, pc41;
  logic        v1, st1;
  logic [3:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        es;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        v;
    logic [15:0] c;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  if_id_stage #(.CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .pc(pc0), .if_id_instr(ins0), .if_id_pc4(pc40), .if_id_valid(v0),
    .stall(st0), .stall_count(cnt0)
  );

  if_id_stage #(.CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .pc(pc1), .if_id_instr(ins1), .if_id_pc4(pc41), .if_id_valid(v1),
    .stall(st1), .stall_count(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs on the falling edge and queue the expectation.
  task automatic cyc(input logic br, input logic [31:0] tgt, input logic mr,
                     input logic [4:0] rt, input logic [31:0] rd, input logic es,
                     input logic [31:0] epc, input logic [31:0] eins,
                     input logic [31:0] epc4, input logic ev, input int ec);
    exp_t e;
    @(negedge clk);
    branch_taken  = br;
    branch_target = tgt;
    ex_MemRead    = mr;
    ex_rt         = rt;
    imem_rdata    = rd;
    e.es  = es;
    e.pc  = epc;
    e.ins = eins;
    e.pc4 = epc4;
    e.v   = ev;
    e.c   = 16'(ec);
    e.c4  = (ec > 15) ? 4'hF : 4'(ec);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {31'd0, st0}, {31'd0, e.es});
        chk("stall_c4", {31'd0, st1}, {31'd0, e.es});
        @(posedge clk);
        #1;
        chk("pc", pc0, e.pc);
        chk("if_id_instr", ins0, e.ins);
        chk("if_id_pc4", pc40, e.pc4);
        chk("if_id_valid", {31'd0, v0}, {31'd0, e.v});
        chk("stall_count", {16'd0, cnt0}, {16'd0, e.c});
        chk("stall_count_c4", {28'd0, cnt1}, {28'd0, e.c4});
        chk("pc_c4", pc1, e.pc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc0, 32'h0);
    chk("rst_instr", ins0, 32'h0);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_stall", {31'd0, st0}, 32'd0);

    cyc(0, 0, 0, 0, 32'h8C22_0004, 0, 32'h4, 32'h8C22_0004, 32'h4, 1, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 32'h0043_0820, 0, 32'h8, 32'h0043_0820, 32'h8, 1, 0);
    // add $1,$2,$3 with load to $3 in EX, then $zero which must not stall
    cyc(0, 0, 1, 3, 32'h1111_1111, 1, 32'h8, 32'h0043_0820, 32'h8, 1, 1);
    cyc(0, 0, 1, 0, 32'h2222_2222, 0, 32'hC, 32'h2222_2222, 32'hC, 1, 1);
    // 0x22222222 has rs=17, rt=2
    cyc(0, 0, 1, 17, 32'h3333_3333, 1, 32'hC, 32'h2222_2222, 32'hC, 1, 2);
    cyc(0, 0, 1, 5, 32'h0043_0820, 0, 32'h10, 32'h0043_0820, 32'h10, 1, 2);
    // redirect wins over a live stall, target low bits dropped
    cyc(1, 32'h103, 1, 2, 32'h4444_4444, 1, 32'h100, 32'h0, 32'h0, 0, 2);
    cyc(0, 0, 1, 1, 32'h8C22_0004, 0, 32'h104, 32'h8C22_0004, 32'h104, 1, 2);
    // pc wrap at the top of the address space
    cyc(1, 32'hFFFF_FFFF, 0, 0, 32'h5555_5555, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 2);
    cyc(0, 0, 0, 0, 32'h0043_0820, 0, 32'h0, 32'h0043_0820, 32'h0, 1, 2);
    // sustained stall: 16-bit counter climbs, 4-bit copy pins at 0xF
    for (int i = 0; i < 20; i++)
      cyc(0, 0, 1, 3, 32'h6666_6666, 1, 32'h0, 32'h0043_0820, 32'h0, 1, 3 + i);
    cyc(0, 0, 0, 0, 32'h0, 0, 32'h4, 32'h0, 32'h4, 1, 22);
    cyc(1, 32'h3C, 0, 0, 32'h0, 0, 32'h3C, 32'h0, 32'h0, 0, 22);
    cyc(0, 0, 0, 0, 32'h0043_0820, 0, 32'h40, 32'h0043_0820, 32'h40, 1, 22);

    // asynchronous reset in the middle of a stall, pc=0x40
    @(negedge clk);
    ex_MemRead = 1'b1;
    ex_rt      = 5'd3;
    #1;
    chk("pre_rst_stall", {31'd0, st0}, 32'd1);
    chk("pre_rst_pc", pc0, 32'h40);
    rst = 1'b1;
    #1;
    chk("async_pc", pc0, 32'h0);
    chk("async_instr", ins0, 32'h0);
    chk("async_pc4", pc40, 32'h0);
    chk("async_valid", {31'd0, v0}, 32'd0);
    chk("async_cnt", {16'd0, cnt0}, 32'd0);
    chk("async_cnt_c4", {28'd0, cnt1}, 32'd0);
    chk("async_stall", {31'd0, st0}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_pc", pc0, 32'h0);

    cyc(0, 0, 0, 0, 32'h8C22_0004, 0, 32'h4, 32'h8C22_0004, 32'h4, 1, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 32'h0043_0820, 0, 32'h8, 32'h0043_0820, 32'h8, 1, 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 32'hC, 32'h0, 32'hC, 1, 0);

    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
